// File: rtl/dram_async_pad_seq.sv
// Sequences the DRAM pad controls (DRAM reset, CKE, pad output-enable) that
// drive the async edge-logic pad cells. It runs the power-up timing sequence
// and self-refresh entry/exit using programmable cycle delays. Every output
// is a registered decode of the next state, so the pads only ever see clean
// levels.
//
// Ports:
//   clk            core clock
//   arst_l         asynchronous active-low reset
//   init_req       pulse, starts power-up (only acted on in RESET)
//   pwr_dn         level, forces RESET from any state (highest priority)
//   sr_enter_req   pulse, enter self-refresh (only acted on in ACTIVE)
//   sr_exit_req    pulse, exit self-refresh (only acted on in SR)
//   dly_pwr        DRAM reset hold after pads are enabled, in cycles
//   dly_cke        wait before CKE rises, also the self-refresh exit settle
//   dram_rst_l_out DRAM reset to pad, active-low
//   cke_out        clock enable to pad
//   pad_oe         pad output enable
//   busy           a timed sequence is in progress
//   init_done      DRAM usable (ACTIVE)
//   in_sr          DRAM in self-refresh (SR)
module dram_async_pad_seq #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             arst_l,
   input  logic             init_req,
   input  logic             pwr_dn,
   input  logic             sr_enter_req,
   input  logic             sr_exit_req,
   input  logic [CNT_W-1:0] dly_pwr,
   input  logic [CNT_W-1:0] dly_cke,
   output logic             dram_rst_l_out,
   output logic             cke_out,
   output logic             pad_oe,
   output logic             busy,
   output logic             init_done,
   output logic             in_sr
);

   typedef enum logic [2:0] {
      S_RESET    = 3'd0,
      S_WAIT_PWR = 3'd1,
      S_WAIT_CKE = 3'd2,
      S_ACTIVE   = 3'd3,
      S_SR       = 3'd4,
      S_SR_EXIT  = 3'd5
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             cnt_zero;

   logic dram_rst_l_d, cke_d, pad_oe_d, busy_d, init_done_d, in_sr_d;

   assign cnt_zero = (cnt_q == '0);

   // State, counter and output registers; outputs follow the state they decode.
   always_ff @(posedge clk or negedge arst_l) begin
      if (!arst_l) begin
         state_q        <= S_RESET;
         cnt_q          <= '0;
         dram_rst_l_out <= 1'b0;
         cke_out        <= 1'b0;
         pad_oe         <= 1'b0;
         busy           <= 1'b0;
         init_done      <= 1'b0;
         in_sr          <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         dram_rst_l_out <= dram_rst_l_d;
         cke_out        <= cke_d;
         pad_oe         <= pad_oe_d;
         busy           <= busy_d;
         init_done      <= init_done_d;
         in_sr          <= in_sr_d;
      end
   end

   // Next state and counter. Delays are sampled only on the load cycle; the
   // counter holds at zero, so an all-ones delay never wraps.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (pwr_dn) begin
         state_d = S_RESET;
         cnt_d   = '0;
      end else begin
         case (state_q)
            S_RESET: begin
               if (init_req) begin
                  state_d = S_WAIT_PWR;
                  cnt_d   = dly_pwr;
               end
            end
            S_WAIT_PWR: begin
               if (cnt_zero) begin
                  state_d = S_WAIT_CKE;
                  cnt_d   = dly_cke;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            S_WAIT_CKE: begin
               if (cnt_zero) begin
                  state_d = S_ACTIVE;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            S_ACTIVE: begin
               if (sr_enter_req) begin
                  state_d = S_SR;
               end
            end
            S_SR: begin
               if (sr_exit_req) begin
                  state_d = S_SR_EXIT;
                  cnt_d   = dly_cke;
               end
            end
            S_SR_EXIT: begin
               if (cnt_zero) begin
                  state_d = S_ACTIVE;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            default: begin
               state_d = S_RESET;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Output decode of the next state, registered above.
   always_comb begin
      dram_rst_l_d = 1'b0;
      cke_d        = 1'b0;
      pad_oe_d     = 1'b0;
      busy_d       = 1'b0;
      init_done_d  = 1'b0;
      in_sr_d      = 1'b0;
      case (state_d)
         S_WAIT_PWR: begin
            pad_oe_d = 1'b1;
            busy_d   = 1'b1;
         end
         S_WAIT_CKE: begin
            pad_oe_d     = 1'b1;
            dram_rst_l_d = 1'b1;
            busy_d       = 1'b1;
         end
         S_ACTIVE: begin
            pad_oe_d     = 1'b1;
            dram_rst_l_d = 1'b1;
            cke_d        = 1'b1;
            init_done_d  = 1'b1;
         end
         S_SR: begin
            pad_oe_d     = 1'b1;
            dram_rst_l_d = 1'b1;
            in_sr_d      = 1'b1;
         end
         S_SR_EXIT: begin
            pad_oe_d     = 1'b1;
            dram_rst_l_d = 1'b1;
            cke_d        = 1'b1;
            busy_d       = 1'b1;
         end
         default: begin
            dram_rst_l_d = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_dram_async_pad_seq.sv
// Directed testbench for dram_async_pad_seq. Outputs are compared as the
// vector {dram_rst_l_out, cke_out, pad_oe, busy, init_done, in_sr}.
module tb_dram_async_pad_seq;

   localparam logic [5:0] E_RST  = 6'b000000;
   localparam logic [5:0] E_WPWR = 6'b001100;
   localparam logic [5:0] E_WCKE = 6'b101100;
   localparam logic [5:0] E_ACT  = 6'b111010;
   localparam logic [5:0] E_SR   = 6'b101001;
   localparam logic [5:0] E_SRX  = 6'b111100;

   logic        clk = 1'b0;
   logic        arst_l = 1'b0;
   logic        init_req = 1'b0, pwr_dn = 1'b0, sr_enter_req = 1'b0, sr_exit_req = 1'b0;
   logic [15:0] dly_pwr = '0, dly_cke = '0;
   logic        dram_rst_l_out, cke_out, pad_oe, busy, init_done, in_sr;

   logic        init_req4 = 1'b0;
   logic [3:0]  dly_pwr4 = '0, dly_cke4 = '0;
   logic        rst4, cke4, oe4, busy4, done4, sr4;

   logic [5:0]  outs, outs4, exp;
   int          vecs = 0;
   int          errs = 0;

   assign outs  = {dram_rst_l_out, cke_out, pad_oe, busy, init_done, in_sr};
   assign outs4 = {rst4, cke4, oe4, busy4, done4, sr4};

   always #5 clk = ~clk;

   dram_async_pad_seq #(.CNT_W(16)) u_dut (
      .clk(clk), .arst_l(arst_l), .init_req(init_req), .pwr_dn(pwr_dn),
      .sr_enter_req(sr_enter_req), .sr_exit_req(sr_exit_req),
      .dly_pwr(dly_pwr), .dly_cke(dly_cke),
      .dram_rst_l_out(dram_rst_l_out), .cke_out(cke_out), .pad_oe(pad_oe),
      .busy(busy), .init_done(init_done), .in_sr(in_sr)
   );

   dram_async_pad_seq #(.CNT_W(4)) u_dut4 (
      .clk(clk), .arst_l(arst_l), .init_req(init_req4), .pwr_dn(1'b0),
      .sr_enter_req(1'b0), .sr_exit_req(1'b0),
      .dly_pwr(dly_pwr4), .dly_cke(dly_cke4),
      .dram_rst_l_out(rst4), .cke_out(cke4), .pad_oe(oe4),
      .busy(busy4), .init_done(done4), .in_sr(sr4)
   );

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Return to RESET through pwr_dn (stimulus only).
   task automatic go_reset();
      pwr_dn = 1'b1;
      step();
      pwr_dn = 1'b0;
   endtask

   task automatic test_reset();
      #3;
      if (outs !== E_RST) begin
         $display("FAIL reset_async: got %b want %b", outs, E_RST);
         errs++;
      end
      vecs++;
      step();
      arst_l = 1'b1;
      step();
      step();
      if (outs !== E_RST) begin
         $display("FAIL reset_idle: got %b want %b", outs, E_RST);
         errs++;
      end
      vecs++;
   endtask

   // dly_pwr=3, dly_cke=2: WAIT_PWR cycles 1-4, WAIT_CKE 5-7, ACTIVE from 8.
   task automatic test_powerup();
      dly_pwr  = 16'd3;
      dly_cke  = 16'd2;
      init_req = 1'b1;
      step();
      init_req = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         exp = (c <= 4) ? E_WPWR : (c <= 7) ? E_WCKE : E_ACT;
         if (outs !== exp) begin
            $display("FAIL powerup_c%0d: got %b want %b", c, outs, exp);
            errs++;
         end
         vecs++;
         if (c < 10) step();
      end
   endtask

   task automatic test_zero_delay();
      go_reset();
      if (outs !== E_RST) begin
         $display("FAIL zero_pwrdn: got %b want %b", outs, E_RST);
         errs++;
      end
      vecs++;
      dly_pwr  = 16'd0;
      dly_cke  = 16'd0;
      init_req = 1'b1;
      step();
      init_req = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         exp = (c == 1) ? E_WPWR : (c == 2) ? E_WCKE : E_ACT;
         if (outs !== exp) begin
            $display("FAIL zero_c%0d: got %b want %b", c, outs, exp);
            errs++;
         end
         vecs++;
         if (c < 4) step();
      end
   endtask

   // CNT_W=4, dly_pwr=15: WAIT_PWR cycles 1-16, WAIT_CKE 17, ACTIVE 18.
   task automatic test_max_delay();
      dly_pwr4  = 4'hF;
      dly_cke4  = 4'h0;
      init_req4 = 1'b1;
      step();
      init_req4 = 1'b0;
      dly_pwr4  = 4'h2;
      for (int c = 1; c <= 19; c++) begin
         exp = (c <= 16) ? E_WPWR : (c == 17) ? E_WCKE : E_ACT;
         if (outs4 !== exp) begin
            $display("FAIL maxdly_c%0d: got %b want %b", c, outs4, exp);
            errs++;
         end
         vecs++;
         if (c < 19) step();
      end
   endtask

   // From ACTIVE: enter SR, hold, exit with dly_cke=4 -> 5 cycles SR_EXIT.
   task automatic test_self_refresh();
      sr_enter_req = 1'b1;
      step();
      sr_enter_req = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         if (outs !== E_SR) begin
            $display("FAIL sr_hold_c%0d: got %b want %b", c, outs, E_SR);
            errs++;
         end
         vecs++;
         step();
      end
      dly_cke     = 16'd4;
      sr_exit_req = 1'b1;
      step();
      sr_exit_req = 1'b0;
      dly_cke     = 16'd0;
      for (int c = 1; c <= 7; c++) begin
         exp = (c <= 5) ? E_SRX : E_ACT;
         if (outs !== exp) begin
            $display("FAIL sr_exit_c%0d: got %b want %b", c, outs, exp);
            errs++;
         end
         vecs++;
         if (c < 7) step();
      end
   endtask

   task automatic test_ignored();
      // sr_exit_req in ACTIVE
      sr_exit_req = 1'b1;
      step();
      sr_exit_req = 1'b0;
      if (outs !== E_ACT) begin
         $display("FAIL ign_exit_in_active: got %b want %b", outs, E_ACT);
         errs++;
      end
      vecs++;
      // init_req together with pwr_dn
      pwr_dn   = 1'b1;
      init_req = 1'b1;
      step();
      pwr_dn   = 1'b0;
      init_req = 1'b0;
      step();
      if (outs !== E_RST) begin
         $display("FAIL ign_init_with_pwrdn: got %b want %b", outs, E_RST);
         errs++;
      end
      vecs++;
      // init_req in WAIT_CKE: WAIT_CKE cycles 2-7 unchanged, ACTIVE at 8
      dly_pwr  = 16'd0;
      dly_cke  = 16'd5;
      init_req = 1'b1;
      step();
      init_req = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         exp = (c == 1) ? E_WPWR : (c <= 7) ? E_WCKE : E_ACT;
         if (outs !== exp) begin
            $display("FAIL ign_init_c%0d: got %b want %b", c, outs, exp);
            errs++;
         end
         vecs++;
         init_req = (c == 2);
         if (c < 8) step();
      end
      init_req = 1'b0;
      // both SR requests in SR with dly_cke=1: SR_EXIT for 2 cycles
      sr_enter_req = 1'b1;
      step();
      if (outs !== E_SR) begin
         $display("FAIL conflict_enter: got %b want %b", outs, E_SR);
         errs++;
      end
      vecs++;
      dly_cke     = 16'd1;
      sr_exit_req = 1'b1;
      step();
      sr_enter_req = 1'b0;
      sr_exit_req  = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         exp = (c <= 2) ? E_SRX : E_ACT;
         if (outs !== exp) begin
            $display("FAIL conflict_c%0d: got %b want %b", c, outs, exp);
            errs++;
         end
         vecs++;
         if (c < 3) step();
      end
   endtask

   task automatic test_abort();
      // pwr_dn during SR_EXIT
      sr_enter_req = 1'b1;
      step();
      sr_enter_req = 1'b0;
      dly_cke      = 16'd4;
      sr_exit_req  = 1'b1;
      step();
      sr_exit_req = 1'b0;
      step();
      if (outs !== E_SRX) begin
         $display("FAIL abort_pre: got %b want %b", outs, E_SRX);
         errs++;
      end
      vecs++;
      pwr_dn = 1'b1;
      step();
      pwr_dn = 1'b0;
      if (outs !== E_RST) begin
         $display("FAIL abort_pwrdn: got %b want %b", outs, E_RST);
         errs++;
      end
      vecs++;
      // arst_l mid-WAIT_PWR, checked before the next clock edge
      dly_pwr  = 16'd10;
      init_req = 1'b1;
      step();
      init_req = 1'b0;
      step();
      if (outs !== E_WPWR) begin
         $display("FAIL abort_wpwr: got %b want %b", outs, E_WPWR);
         errs++;
      end
      vecs++;
      #2 arst_l = 1'b0;
      #1;
      if (outs !== E_RST) begin
         $display("FAIL abort_arst: got %b want %b", outs, E_RST);
         errs++;
      end
      vecs++;
      step();
      arst_l = 1'b1;
      for (int c = 1; c <= 12; c++) step();
      if (outs !== E_RST) begin
         $display("FAIL abort_stay_reset: got %b want %b", outs, E_RST);
         errs++;
      end
      vecs++;
   endtask

   // dly_cke changed 6 -> 1 during WAIT_CKE: WAIT_CKE cycles 2-8, ACTIVE 9.
   task automatic test_dly_change();
      dly_pwr  = 16'd0;
      dly_cke  = 16'd6;
      init_req = 1'b1;
      step();
      init_req = 1'b0;
      for (int c = 1; c <= 9; c++) begin
         exp = (c == 1) ? E_WPWR : (c <= 8) ? E_WCKE : E_ACT;
         if (outs !== exp) begin
            $display("FAIL dlychg_c%0d: got %b want %b", c, outs, exp);
            errs++;
         end
         vecs++;
         if (c == 3) dly_cke = 16'd1;
         if (c < 9) step();
      end
   endtask

   initial begin
      test_reset();
      test_powerup();
      test_zero_delay();
      test_max_delay();
      test_self_refresh();
      test_ignored();
      test_abort();
      test_dly_change();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/dram_async_pad_seq.md
Name: dram_async_pad_seq

Overview:
Sequences the asynchronous DRAM pad controls (DRAM reset, CKE, pad output-enable) that feed the async edge-logic pad cells. It runs the power-up timing sequence and self-refresh entry/exit under programmable cycle delays. It sits between the DRAM controller core and the async pad edge logic. Every pad-facing output is registered, so the passthrough pad cells see glitch-free levels.

Parameters:
CNT_W, 16, width of the delay inputs and the internal down-counter

Ports:
clk  input  1  core clock
arst_l  input  1  reset; asynchronous, active-low
init_req  input  1  one-cycle pulse; starts the power-up sequence (honoured only in RESET)
pwr_dn  input  1  synchronous level; forces a return to RESET from any state
sr_enter_req  input  1  one-cycle pulse; enter self-refresh (honoured only in ACTIVE)
sr_exit_req  input  1  one-cycle pulse; exit self-refresh (honoured only in SR)
dly_pwr  input  CNT_W  hold time of DRAM reset after pads are enabled, in cycles
dly_cke  input  CNT_W  wait time before CKE rises and the self-refresh exit settle time, in cycles
dram_rst_l_out  output  1  to async pad: DRAM reset, active-low
cke_out  output  1  to async pad: clock enable
pad_oe  output  1  to async pad: output enable
busy  output  1  sequence in progress
init_done  output  1  DRAM usable (state ACTIVE)
in_sr  output  1  DRAM in self-refresh (state SR)

Behaviour:
- Reset (arst_l=0, asynchronous):
  - state=RESET, counter=0.
  - All outputs 0 (dram_rst_l_out=0 holds DRAM in reset; cke_out=0; pad_oe=0; busy=0; init_done=0; in_sr=0).
- All outputs are registered and are a pure decode of the state. Output changes appear 1 cycle after the qualifying input edge.
- States and output values:
  - RESET: all outputs 0.
  - WAIT_PWR: pad_oe=1, dram_rst_l_out=0, cke_out=0, busy=1.
  - WAIT_CKE: pad_oe=1, dram_rst_l_out=1, cke_out=0, busy=1.
  - ACTIVE: pad_oe=1, dram_rst_l_out=1, cke_out=1, init_done=1.
  - SR: pad_oe=1, dram_rst_l_out=1, cke_out=0, in_sr=1.
  - SR_EXIT: pad_oe=1, dram_rst_l_out=1, cke_out=1, busy=1.
- Transitions:
  - RESET + init_req -> WAIT_PWR; counter loads dly_pwr.
  - WAIT_PWR, counter==0 -> WAIT_CKE; counter loads dly_cke. Otherwise the counter decrements.
  - WAIT_CKE, counter==0 -> ACTIVE. Otherwise the counter decrements.
  - ACTIVE + sr_enter_req -> SR.
  - SR + sr_exit_req -> SR_EXIT; counter loads dly_cke.
  - SR_EXIT, counter==0 -> ACTIVE. Otherwise the counter decrements.
- Wait-state duration:
  - Each wait state lasts exactly dly+1 cycles.
  - dly=0 gives a 1-cycle stay.
  - dly=all-ones gives 2^CNT_W cycles with no wrap-around; the counter never decrements below 0.
- Delay sampling: dly_pwr and dly_cke are sampled only on the load cycle. Changes mid-count have no effect.
- Precedence: pwr_dn > all other inputs. pwr_dn=1 in any state -> RESET next cycle; the counter clears and outputs return to their reset values.
- Requests that are ignored (no state change, no latching):
  - init_req outside RESET.
  - sr_enter_req outside ACTIVE.
  - sr_exit_req outside SR.
  - init_req together with pwr_dn.
- Simultaneous sr_enter_req and sr_exit_req: only the request valid in the current state acts.
- Reset asserted mid-sequence aborts immediately and asynchronously to the RESET outputs. After arst_l deasserts, the block waits for a fresh init_req.
- Invariants:
  - cke_out=1 implies dram_rst_l_out=1.
  - dram_rst_l_out=1 implies pad_oe=1.
  - busy, init_done and in_sr are mutually exclusive.

Test Plan:
- Power-up with dly_pwr=3, dly_cke=2: init_req pulse at cycle 0 -> pad_oe rises at cycle 1 → dram_rst_l_out rises at cycle 5 → cke_out and init_done rise at cycle 8 (busy=1 over cycles 1-7).
- Zero delays (dly_pwr=0, dly_cke=0): init_req -> WAIT_PWR 1 cycle, WAIT_CKE 1 cycle, init_done=1 at cycle 3. Then a max-delay run with CNT_W=4, dly_pwr=15 -> WAIT_PWR held exactly 16 cycles.
- Self-refresh: in ACTIVE, sr_enter_req -> cke_out=0, in_sr=1 the next cycle. sr_exit_req with dly_cke=4 -> cke_out=1, busy=1 for 5 cycles, then init_done=1.
- Ignored and conflicting requests: sr_exit_req in ACTIVE, init_req in WAIT_CKE, and sr_enter_req together with sr_exit_req in SR -> respectively no change, no change, and SR_EXIT entered.
- Abort: pwr_dn=1 during SR_EXIT -> all outputs 0 the next cycle. Separately, arst_l pulled low mid-WAIT_PWR -> outputs 0 immediately without waiting for a clk edge; with no further init_req after release, the block stays in RESET.
- Delay change mid-count: dly_cke changed from 6 to 1 during WAIT_CKE -> WAIT_CKE still lasts 7 cycles.
